// File: rtl/knight_rider_pkg.sv
// Shared scanner definitions: state encodings, a width helper and the default
// step rate. The pwm stage reuses these constants.
package knight_rider_pkg;

  // 25 MHz-class clock divided to a visible step rate
  localparam int DEF_TICK_DIV = 25_000_000;

  localparam int ST_W = 5;

  localparam logic [ST_W-1:0] ST_IDLE    = 5'b00001;
  localparam logic [ST_W-1:0] ST_UP      = 5'b00010;
  localparam logic [ST_W-1:0] ST_HOLD_HI = 5'b00100;
  localparam logic [ST_W-1:0] ST_DOWN    = 5'b01000;
  localparam logic [ST_W-1:0] ST_HOLD_LO = 5'b10000;

  typedef enum logic [ST_W-1:0] {
    IDLE    = ST_IDLE,
    UP      = ST_UP,
    HOLD_HI = ST_HOLD_HI,
    DOWN    = ST_DOWN,
    HOLD_LO = ST_HOLD_LO
  } kr_state_t;

  // Bits needed to index v items; never returns less than 1 so a
  // degenerate range still yields a legal vector.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/knight_rider_scanner_tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV enabled cycles.
// Dropping en clears the count, so a re-enable always starts a full period.
module tick_prescaler #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 32
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_LAST);

  // count while enabled, wrap on tick, hold at zero while disabled
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (!en || tick)  cnt <= '0;
    else                   cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/knight_rider_scanner.sv
// Knight-rider LED scanner: a bright head bounces across N_LEDS outputs,
// optionally dwelling HOLD_STEPS extra steps at each end. The previous head
// position is lit only while pwm_in is high, giving a dimmed trail.
module knight_rider_scanner
  import knight_rider_pkg::*;
#(
  parameter int N_LEDS     = 8,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int CNT_W      = 32,
  parameter int HOLD_STEPS = 1
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pwm_in,
  output logic [N_LEDS-1:0] leds,
  output logic              dir,
  output logic              step_pulse
);

  localparam int POS_W  = clog2(N_LEDS);
  localparam int HOLD_W = clog2(HOLD_STEPS + 1);

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0]  POS_PRE   = POS_W'(N_LEDS - 2);
  localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

  kr_state_t          state, state_n;
  logic [POS_W-1:0]   pos, pos_n, prev_pos, prev_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic               dir_n;
  logic               run_en, tick;
  logic [N_LEDS-1:0]  head, tail;

  // Prescaler only runs once the FSM has left IDLE, so the entry cycle
  // never steps and UP always begins with a fresh count.
  assign run_en = en && (state != IDLE);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_presc (
    .clk1  (clk1),
    .rst_n (rst_n),
    .en    (run_en),
    .tick  (tick)
  );

  assign head = N_LEDS'(1) << pos;
  assign tail = (N_LEDS'(1) << prev_pos) & {N_LEDS{pwm_in}};

  // next-state, position and dwell bookkeeping; en low aborts to IDLE
  always_comb begin
    state_n = state;
    pos_n   = pos;
    prev_n  = prev_pos;
    hold_n  = hold_cnt;
    if (!en) begin
      state_n = IDLE;
      pos_n   = '0;
      prev_n  = '0;
      hold_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = UP;
          pos_n   = '0;
          prev_n  = '0;
          hold_n  = '0;
        end
        UP: if (tick) begin
          prev_n = pos;
          pos_n  = pos + POS_ONE;
          if (pos == POS_PRE) state_n = (HOLD_STEPS > 0) ? HOLD_HI : DOWN;
        end
        HOLD_HI: if (tick) begin
          prev_n = pos;
          if (hold_cnt == HOLD_LAST) begin
            state_n = DOWN;
            hold_n  = '0;
          end else begin
            hold_n  = hold_cnt + HOLD_W'(1);
          end
        end
        DOWN: if (tick) begin
          prev_n = pos;
          pos_n  = pos - POS_ONE;
          if (pos == POS_ONE) state_n = (HOLD_STEPS > 0) ? HOLD_LO : UP;
        end
        HOLD_LO: if (tick) begin
          prev_n = pos;
          if (hold_cnt == HOLD_LAST) begin
            state_n = UP;
            hold_n  = '0;
          end else begin
            hold_n  = hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          pos_n   = '0;
          prev_n  = '0;
          hold_n  = '0;
        end
      endcase
    end
  end

  // direction follows the state being entered; IDLE keeps the last value
  always_comb begin
    dir_n = dir;
    case (state_n)
      UP, HOLD_HI:   dir_n = 1'b1;
      DOWN, HOLD_LO: dir_n = 1'b0;
      default:       dir_n = dir;
    endcase
  end

  // FSM and position registers
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pos      <= '0;
      prev_pos <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      prev_pos <= prev_n;
      hold_cnt <= hold_n;
    end
  end

  // registered LED drive, step strobe and direction; dark while idle or disabled
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      leds       <= '0;
      dir        <= 1'b1;
      step_pulse <= 1'b0;
    end else begin
      leds       <= (!en || state == IDLE) ? '0 : (head | tail);
      dir        <= dir_n;
      step_pulse <= tick;
    end
  end

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Bench for knight_rider_scanner: three instances share the inputs
// (TICK_DIV=4/HOLD=0, TICK_DIV=4/HOLD=2, TICK_DIV=1/HOLD=0) and are compared
// against a step-indexed bounce model.
module tb_knight_rider_scanner;

  localparam int N = 8;

  logic clk1 = 1'b0;
  logic rst_n, en, pwm_in;
  logic [7:0] leds_o [3];
  logic       dir_o  [3];
  logic       step_o [3];

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  knight_rider_scanner #(.N_LEDS(8), .TICK_DIV(4), .CNT_W(8), .HOLD_STEPS(0)) dut0 (
    .clk1(clk1), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
    .leds(leds_o[0]), .dir(dir_o[0]), .step_pulse(step_o[0]));
  knight_rider_scanner #(.N_LEDS(8), .TICK_DIV(4), .CNT_W(8), .HOLD_STEPS(2)) dut1 (
    .clk1(clk1), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
    .leds(leds_o[1]), .dir(dir_o[1]), .step_pulse(step_o[1]));
  knight_rider_scanner #(.N_LEDS(8), .TICK_DIV(1), .CNT_W(8), .HOLD_STEPS(0)) dut2 (
    .clk1(clk1), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
    .leds(leds_o[2]), .dir(dir_o[2]), .step_pulse(step_o[2]));

  // ---------------- reference model ----------------
  function automatic int td_of(int c);
    return (c == 2) ? 1 : 4;
  endfunction
  function automatic int h_of(int c);
    return (c == 1) ? 2 : 0;
  endfunction

  // Head position after s steps: one bounce period is h+1 visits at each end
  // plus the N-2 interior positions each way; a run starts at the bottom
  // without dwelling there.
  function automatic int pos_at(int h, int s);
    int l, j;
    l = 2*(N-1) + 2*h;
    j = (s + h) % l;
    if (j <= h)             return 0;
    if (j < h + N - 1)      return j - h;
    if (j <= 2*h + N - 1)   return N - 1;
    return N - 1 - (j - (2*h + N - 1));
  endfunction
  function automatic int prev_at(int h, int s);
    return (s == 0) ? 0 : pos_at(h, s - 1);
  endfunction
  function automatic bit dir_at(int h, int s);
    int a, b;
    a = pos_at(h, s);
    b = pos_at(h, s + 1);
    if (b > a) return 1'b1;
    if (b < a) return 1'b0;
    return (a == N - 1);
  endfunction
  function automatic logic [7:0] oh(int p);
    logic [7:0] one;
    one = 8'd1;
    return one << p;
  endfunction

  bit         run   [3];
  int         cyc   [3];
  int         s     [3];
  logic [7:0] e_leds[3];
  logic       e_dir [3];
  logic       e_step[3];

  always @(posedge clk1 or negedge rst_n) begin
    for (int c = 0; c < 3; c++) begin
      if (!rst_n) begin
        run[c] <= 1'b0; cyc[c] <= 0; s[c] <= 0;
        e_leds[c] <= 8'h00; e_dir[c] <= 1'b1; e_step[c] <= 1'b0;
      end else if (!en) begin
        run[c] <= 1'b0; cyc[c] <= 0; s[c] <= 0;
        e_leds[c] <= 8'h00; e_step[c] <= 1'b0;
      end else if (!run[c]) begin
        run[c] <= 1'b1; cyc[c] <= 0; s[c] <= 0;
        e_leds[c] <= 8'h00; e_step[c] <= 1'b0; e_dir[c] <= dir_at(h_of(c), 0);
      end else begin
        e_leds[c] <= oh(pos_at(h_of(c), s[c])) | (oh(prev_at(h_of(c), s[c])) & {8{pwm_in}});
        cyc[c] <= cyc[c] + 1;
        if ((cyc[c] + 1) % td_of(c) == 0) begin
          s[c]      <= s[c] + 1;
          e_step[c] <= 1'b1;
          e_dir[c]  <= dir_at(h_of(c), s[c] + 1);
        end else begin
          e_step[c] <= 1'b0;
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; pwm_in = 1'b1;
    repeat (3) @(negedge clk1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk1);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (leds_o[c] !== 8'h00 || dir_o[c] !== 1'b1 || step_o[c] !== 1'b0) begin
          errors++;
          $display("FAIL reset dut%0d cyc%0d: leds=%h dir=%b step=%b, expected leds=00 dir=1 step=0",
                   c, i, leds_o[c], dir_o[c], step_o[c]);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_seq [14] = '{8'h01, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60,
                                 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
    logic [7:0] seq [$];
    logic [7:0] last;
    last = 8'h00;
    en = 1'b1; pwm_in = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk1);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (leds_o[c] !== e_leds[c] || dir_o[c] !== e_dir[c] || step_o[c] !== e_step[c]) begin
          errors++;
          $display("FAIL sweep dut%0d: leds=%h dir=%b step=%b, expected leds=%h dir=%b step=%b",
                   c, leds_o[c], dir_o[c], step_o[c], e_leds[c], e_dir[c], e_step[c]);
        end
      end
      if (leds_o[0] != 8'h00 && leds_o[0] != last) begin
        seq.push_back(leds_o[0]);
        if (seq.size() == 9) begin
          checks++;
          if (dir_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL sweep_turn_dir: dir=%b with leds=%h, expected dir=0", dir_o[0], leds_o[0]);
          end
        end
      end
      last = leds_o[0];
    end
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (k >= seq.size()) begin
        errors++;
        $display("FAIL sweep_seq[%0d]: missing, expected %h", k, exp_seq[k]);
      end else if (seq[k] !== exp_seq[k]) begin
        errors++;
        $display("FAIL sweep_seq[%0d]: got %h, expected %h", k, seq[k], exp_seq[k]);
      end
    end
  endtask

  task automatic test_pwm_zero();
    pwm_in = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk1);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (leds_o[c] !== e_leds[c] || dir_o[c] !== e_dir[c] || step_o[c] !== e_step[c]) begin
          errors++;
          $display("FAIL pwm_zero dut%0d: leds=%h dir=%b step=%b, expected leds=%h dir=%b step=%b",
                   c, leds_o[c], dir_o[c], step_o[c], e_leds[c], e_dir[c], e_step[c]);
        end
      end
      if (i >= 1) begin
        checks++;
        if ($countones(leds_o[0]) != 1) begin
          errors++;
          $display("FAIL pwm_zero_onehot: leds=%h, expected exactly one bit", leds_o[0]);
        end
      end
    end
  endtask

  task automatic test_random_pwm();
    for (int i = 0; i < 120; i++) begin
      pwm_in = 1'($urandom_range(0, 1));
      @(negedge clk1);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (leds_o[c] !== e_leds[c] || dir_o[c] !== e_dir[c] || step_o[c] !== e_step[c]) begin
          errors++;
          $display("FAIL random_pwm dut%0d: leds=%h dir=%b step=%b, expected leds=%h dir=%b step=%b",
                   c, leds_o[c], dir_o[c], step_o[c], e_leds[c], e_dir[c], e_step[c]);
        end
      end
    end
  endtask

  task automatic test_hold();
    int  run_hi, run_lo;
    bit  got_hi, got_lo;
    run_hi = 0; run_lo = 0; got_hi = 0; got_lo = 0;
    en = 1'b0;
    @(negedge clk1);
    en = 1'b1; pwm_in = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk1);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (leds_o[c] !== e_leds[c] || dir_o[c] !== e_dir[c] || step_o[c] !== e_step[c]) begin
          errors++;
          $display("FAIL hold dut%0d: leds=%h dir=%b step=%b, expected leds=%h dir=%b step=%b",
                   c, leds_o[c], dir_o[c], step_o[c], e_leds[c], e_dir[c], e_step[c]);
        end
      end
      if (leds_o[1] == 8'h80) run_hi++;
      else begin
        if (run_hi > 0 && !got_hi) begin
          got_hi = 1;
          checks++;
          if (run_hi != 12) begin
            errors++;
            $display("FAIL hold_top_dwell: %0d cycles at 80, expected 12", run_hi);
          end
        end
        run_hi = 0;
      end
      if (got_hi && leds_o[1] == 8'h01) run_lo++;
      else begin
        if (run_lo > 0 && !got_lo) begin
          got_lo = 1;
          checks++;
          if (run_lo != 12) begin
            errors++;
            $display("FAIL hold_bottom_dwell: %0d cycles at 01, expected 12", run_lo);
          end
        end
        run_lo = 0;
      end
    end
    if (!got_hi || !got_lo) begin
      checks++; errors++;
      $display("FAIL hold_timeout: top seen=%0d bottom seen=%0d, expected both 1", got_hi, got_lo);
    end
  endtask

  task automatic test_en_drop();
    bit found;
    found = 0;
    pwm_in = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk1);
      if (run[0] && pos_at(0, s[0]) == 5 && e_dir[0] == 1'b1 && ((cyc[0] + 1) % 4) == 0) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL en_drop_timeout: pos 5 tick cycle not reached, expected within 200 cycles");
    end else begin
      en = 1'b0;
      @(negedge clk1);
      checks++;
      if (leds_o[0] !== 8'h00 || step_o[0] !== 1'b0 || dir_o[0] !== 1'b1) begin
        errors++;
        $display("FAIL en_drop: leds=%h step=%b dir=%b, expected leds=00 step=0 dir=1",
                 leds_o[0], step_o[0], dir_o[0]);
      end
      en = 1'b1;
      @(negedge clk1);
      @(negedge clk1);
      checks++;
      if (leds_o[0] !== 8'h01 || dir_o[0] !== 1'b1) begin
        errors++;
        $display("FAIL en_restart: leds=%h dir=%b, expected leds=01 dir=1", leds_o[0], dir_o[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    int steps;
    found = 0; steps = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk1);
      if (run[0] && e_dir[0] == 1'b0 && pos_at(0, s[0]) >= 2 && pos_at(0, s[0]) <= 5) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL async_reset_timeout: DOWN sweep not reached, expected within 200 cycles");
    end
    @(posedge clk1);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (leds_o[c] !== 8'h00 || dir_o[c] !== 1'b1 || step_o[c] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset dut%0d: leds=%h dir=%b step=%b, expected leds=00 dir=1 step=0",
                 c, leds_o[c], dir_o[c], step_o[c]);
      end
    end
    @(negedge clk1);
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk1);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (leds_o[c] !== e_leds[c] || dir_o[c] !== e_dir[c] || step_o[c] !== e_step[c]) begin
          errors++;
          $display("FAIL post_reset dut%0d: leds=%h dir=%b step=%b, expected leds=%h dir=%b step=%b",
                   c, leds_o[c], dir_o[c], step_o[c], e_leds[c], e_dir[c], e_step[c]);
        end
      end
      if (i >= 1 && step_o[2] === 1'b1) steps++;
    end
    checks++;
    if (steps != 29) begin
      errors++;
      $display("FAIL tick1_steps: %0d steps in 29 cycles, expected 29", steps);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_pwm_zero();
    test_random_pwm();
    test_hold();
    test_en_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
